morra_player_driver: RTL and testbench
======================================

MORRA_PLAYER_DRIVER -- requirements
Module: morra_player_driver

Interface
REQ-001 Parameter MAX_ROUNDS, default 20, SHALL set the round limit after which the match is aborted with an error.
REQ-002 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 RST  in  1  SHALL be the reset, synchronous and active-high.
REQ-004 GO  in  1  SHALL request a new match; it is sampled only in IDLE and DONE.
REQ-005 LEN  in  4  SHALL be the match-length code presented to the referee on START.
REQ-006 SEED  in  8  SHALL be the move-generator seed, sampled with GO.
REQ-007 ROUND  in  2  SHALL be the referee round result: 00 null, 01 P1, 10 P2, 11 tie.
REQ-008 GAME  in  2  SHALL be the referee game result: 00 ongoing, 01 P1, 10 P2, 11 draw.
REQ-009 P1, P2  out  2 each  SHALL be the moves driven to the referee: 00 none, 01 rock, 10 paper, 11 scissors.
REQ-010 START  out  1  SHALL be the one-cycle match-start strobe to the referee.
REQ-011 BUSY  out  1  SHALL be high in LOAD, PLAY and WAIT.
REQ-012 DONE  out  1  SHALL be high in DONE.
REQ-013 WINNER  out  2  SHALL be the final result, in GAME encoding.
REQ-014 WINS1, WINS2, TIES  out  5 each  SHALL be the round tallies.
REQ-015 ERR  out  1  SHALL be the sticky error flag.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 The FSM states SHALL be IDLE, LOAD, PLAY, WAIT and DONE.
REQ-018 In IDLE or DONE, GO=1 SHALL cause a transition to LOAD on the next edge, capture SEED, and clear the tallies, the round counter, ERR, WINNER and the previous-win record.
REQ-019 In LOAD, START SHALL be 1 with P1=LEN[3:2] and P2=LEN[1:0] for exactly one cycle; the FSM SHALL then enter PLAY.
REQ-020 In LOAD, the 8-bit LFSR SHALL load SEED, or 8'hA5 when SEED=0.
REQ-021 The LFSR SHALL be Fibonacci, shift-left, taps x^8+x^6+x^5+x^4+1, and SHALL advance once per PLAY cycle, after its value is used.
REQ-022 In PLAY, the P1 candidate SHALL be LFSR[1:0] and the P2 candidate LFSR[3:2], with a candidate of 00 mapped to 01.
REQ-023 In PLAY, if a player won the previous decided round and its candidate equals that round's winning move, the candidate SHALL rotate 01->10->11->01.
REQ-024 A tie SHALL clear the previous-win record.
REQ-025 In PLAY, the FSM SHALL enter WAIT on the next edge.
REQ-026 In WAIT, P1=P2=00 SHALL be driven, so the referee registers a null round, and ROUND/GAME SHALL be sampled.
REQ-027 In WAIT, ROUND=01 SHALL increment WINS1, 10 SHALL increment WINS2 and 11 SHALL increment TIES.
REQ-028 In WAIT, ROUND=00 SHALL set ERR, with no tally change.
REQ-029 Each WAIT cycle SHALL increment the round counter.
REQ-030 In WAIT, after tallying: if GAME!=00, the FSM SHALL go to DONE with WINNER=GAME.
REQ-031 In WAIT, if GAME=00 and the round count equals MAX_ROUNDS, the FSM SHALL go to DONE with WINNER=00 and ERR=1.
REQ-032 In WAIT, if neither REQ-030 nor REQ-031 applies, the FSM SHALL return to PLAY.
REQ-033 The checks of REQ-030 and REQ-031 SHALL follow the same-cycle tally update.
REQ-034 GO SHALL be ignored in LOAD, PLAY and WAIT.
REQ-035 The tallies SHALL saturate at 31.
REQ-036 Outside LOAD, START SHALL be 0 and P1/P2 SHALL be 00 except in PLAY.
REQ-037 DONE, WINNER, the tallies and ERR SHALL hold until the next GO or RST.

Reset
REQ-038 RST=1 SHALL force IDLE on the next edge from any state, including mid-match.
REQ-039 On reset, all outputs SHALL be 0, the LFSR SHALL be 8'hA5, and the round counter and previous-win record SHALL be cleared.
REQ-040 RST SHALL take priority over GO.

Verification
REQ-041 Scenario: RST during WAIT of round 3 -> next cycle all outputs 0, BUSY=0, START=0.
REQ-042 Scenario: GO=1, LEN=4'b0011, SEED=0 in IDLE -> next cycle START=1, P1=00, P2=11, BUSY=1 for one cycle; following PLAY shows P1=01, P2=01.
REQ-043 Scenario: referee model returns ROUND=01 after P1=01 -> in the next PLAY, a P1 candidate of 01 is driven as 10; WINS1=1.
REQ-044 Scenario: model returns ROUND=11, GAME=00 forever -> DONE after 20 WAIT cycles, TIES=20, WINNER=00, ERR=1.
REQ-045 Scenario: model returns ROUND=10 and GAME=10 in the third WAIT -> DONE=1, WINNER=10, WINS2 equal to rounds won by P2; GO pulses during PLAY/WAIT are ignored.
REQ-046 Scenario: model returns ROUND=00 in one WAIT -> ERR=1 sticky, tallies unchanged for that round, play continues.

Source files
------------

// File: rtl/morra_player_driver.sv
// Morra player driver: runs one match against an external referee, generating both
// players' moves from an LFSR and keeping round tallies until the referee calls a result.
module morra_player_driver #(
  parameter int unsigned MAX_ROUNDS = 20
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       GO,
  input  logic [3:0] LEN,
  input  logic [7:0] SEED,
  input  logic [1:0] ROUND,
  input  logic [1:0] GAME,
  output logic [1:0] P1,
  output logic [1:0] P2,
  output logic       START,
  output logic       BUSY,
  output logic       DONE,
  output logic [1:0] WINNER,
  output logic [4:0] WINS1,
  output logic [4:0] WINS2,
  output logic [4:0] TIES,
  output logic       ERR
);

  localparam int unsigned CntW     = $clog2(MAX_ROUNDS + 1);
  localparam logic [7:0]  LfsrInit = 8'hA5;

  typedef enum logic [2:0] {StIdle, StLoad, StPlay, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic [7:0]      lfsr_q, lfsr_d, seed_q, seed_d, load_val;
  logic [CntW-1:0] rnd_q, rnd_d, rnd_inc;
  logic [1:0]      pw_q, pw_d, pm_q, pm_d, last1_q, last1_d, last2_q, last2_d;
  logic [1:0]      p1_q, p1_d, p2_q, p2_d, winner_q, winner_d;
  logic            start_q, start_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [4:0]      wins1_q, wins1_d, wins2_q, wins2_d, ties_q, ties_d;

  // Map raw 00 to rock, then step away from the move that just won for this player.
  function automatic logic [1:0] pick(input logic [1:0] raw, input logic won,
                                      input logic [1:0] win_move);
    logic [1:0] m;
    m = (raw == 2'b00) ? 2'b01 : raw;
    if (won && (m == win_move)) m = (m == 2'b11) ? 2'b01 : m + 2'b01;
    return m;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v == 5'd31) ? v : v + 5'd1;
  endfunction

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    seed_d   = seed_q;
    rnd_d    = rnd_q;
    pw_d     = pw_q;
    pm_d     = pm_q;
    last1_d  = last1_q;
    last2_d  = last2_q;
    winner_d = winner_q;
    err_d    = err_q;
    wins1_d  = wins1_q;
    wins2_d  = wins2_q;
    ties_d   = ties_q;
    p1_d     = 2'b00;
    p2_d     = 2'b00;
    start_d  = 1'b0;
    rnd_inc  = rnd_q + CntW'(1);
    load_val = (seed_q == 8'h00) ? LfsrInit : seed_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (GO) begin
          state_d  = StLoad;
          seed_d   = SEED;
          rnd_d    = '0;
          pw_d     = 2'b00;
          pm_d     = 2'b00;
          winner_d = 2'b00;
          err_d    = 1'b0;
          wins1_d  = 5'd0;
          wins2_d  = 5'd0;
          ties_d   = 5'd0;
          start_d  = 1'b1;
          p1_d     = LEN[3:2];
          p2_d     = LEN[1:0];
        end
      end
      StLoad: begin
        state_d = StPlay;
        lfsr_d  = load_val;
        p1_d    = pick(load_val[1:0], pw_q == 2'b01, pm_q);
        p2_d    = pick(load_val[3:2], pw_q == 2'b10, pm_q);
      end
      StPlay: begin
        state_d = StWait;
        lfsr_d  = lfsr_step(lfsr_q);
        last1_d = p1_q;
        last2_d = p2_q;
      end
      StWait: begin
        rnd_d = rnd_inc;
        unique case (ROUND)
          2'b01: begin
            wins1_d = sat_inc(wins1_q);
            pw_d    = 2'b01;
            pm_d    = last1_q;
          end
          2'b10: begin
            wins2_d = sat_inc(wins2_q);
            pw_d    = 2'b10;
            pm_d    = last2_q;
          end
          2'b11: begin
            ties_d = sat_inc(ties_q);
            pw_d   = 2'b00;
          end
          default: err_d = 1'b1;
        endcase
        if (GAME != 2'b00) begin
          state_d  = StDone;
          winner_d = GAME;
        end else if (rnd_inc == CntW'(MAX_ROUNDS)) begin
          state_d  = StDone;
          winner_d = 2'b00;
          err_d    = 1'b1;
        end else begin
          // Moves for the next PLAY use the record as updated by this round.
          state_d = StPlay;
          p1_d    = pick(lfsr_q[1:0], pw_d == 2'b01, pm_d);
          p2_d    = pick(lfsr_q[3:2], pw_d == 2'b10, pm_d);
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StLoad) || (state_d == StPlay) || (state_d == StWait);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q  <= StIdle;
      lfsr_q   <= LfsrInit;
      seed_q   <= 8'h00;
      rnd_q    <= '0;
      pw_q     <= 2'b00;
      pm_q     <= 2'b00;
      last1_q  <= 2'b00;
      last2_q  <= 2'b00;
      p1_q     <= 2'b00;
      p2_q     <= 2'b00;
      winner_q <= 2'b00;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      wins1_q  <= 5'd0;
      wins2_q  <= 5'd0;
      ties_q   <= 5'd0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      seed_q   <= seed_d;
      rnd_q    <= rnd_d;
      pw_q     <= pw_d;
      pm_q     <= pm_d;
      last1_q  <= last1_d;
      last2_q  <= last2_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      winner_q <= winner_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      wins1_q  <= wins1_d;
      wins2_q  <= wins2_d;
      ties_q   <= ties_d;
    end
  end

  assign P1     = p1_q;
  assign P2     = p2_q;
  assign START  = start_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign WINNER = winner_q;
  assign WINS1  = wins1_q;
  assign WINS2  = wins2_q;
  assign TIES   = ties_q;
  assign ERR    = err_q;

endmodule

// File: tb/tb_morra_player_driver.sv
// Bench for morra_player_driver: acts as the referee and predicts every driven move and
// tally from a round-level model of the match.
module tb_morra_player_driver;

  localparam int MAXR = 20;

  logic       clk;
  logic       RST, GO;
  logic [3:0] LEN;
  logic [7:0] SEED;
  logic [1:0] ROUND, GAME;
  logic [1:0] P1, P2, WINNER;
  logic       START, BUSY, DONE, ERR;
  logic [4:0] WINS1, WINS2, TIES;

  int n_assert = 0;
  int n_fail   = 0;

  morra_player_driver #(.MAX_ROUNDS(MAXR)) dut (
    .clk(clk), .RST(RST), .GO(GO), .LEN(LEN), .SEED(SEED), .ROUND(ROUND), .GAME(GAME),
    .P1(P1), .P2(P2), .START(START), .BUSY(BUSY), .DONE(DONE), .WINNER(WINNER),
    .WINS1(WINS1), .WINS2(WINS2), .TIES(TIES), .ERR(ERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_p1"}, 8'(P1), 0);
    check({tag, "_p2"}, 8'(P2), 0);
    check({tag, "_start"}, 8'(START), 0);
    check({tag, "_busy"}, 8'(BUSY), 0);
    check({tag, "_done"}, 8'(DONE), 0);
    check({tag, "_winner"}, 8'(WINNER), 0);
    check({tag, "_wins1"}, 8'(WINS1), 0);
    check({tag, "_wins2"}, 8'(WINS2), 0);
    check({tag, "_ties"}, 8'(TIES), 0);
    check({tag, "_err"}, 8'(ERR), 0);
  endtask

  // x^8+x^6+x^5+x^4+1, shifting left, feedback into bit 0.
  function automatic int lfsr_next(input int x);
    int fb;
    fb = ((x / 128) + (x / 32) + (x / 16) + (x / 8)) % 2;
    return ((x * 2) % 256) + fb;
  endfunction

  function automatic int move_of(input int raw, input bit won, input int win_move);
    int m;
    m = (raw == 0) ? 1 : raw;
    if (won && m == win_move) m = (m == 3) ? 1 : m + 1;
    return m;
  endfunction

  // Rock 1, paper 2, scissors 3; returns round code 1 (P1), 2 (P2), 3 (tie).
  function automatic int rps(input int a, input int b);
    if (a == b) return 3;
    return (((a - b + 3) % 3) == 1) ? 1 : 2;
  endfunction

  // Referee policies: 0 rps with random null rounds, 1 always tie, 2 always P2,
  // 3 null in round 2, 4 P1 takes round 1, 5 draw declared in round 2.
  function automatic int referee(input int pol, input int r, input int a, input int b);
    case (pol)
      0: return ($urandom_range(0, 7) == 0) ? 0 : rps(a, b);
      1: return 3;
      2: return 2;
      3: return (r == 2) ? 0 : rps(a, b);
      4: return (r == 1) ? 1 : rps(a, b);
      default: return 3;
    endcase
  endfunction

  task automatic run_match(input logic [7:0] seed, input logic [3:0] len, input int pol,
                           input int target, input int rst_round, input bit go_pulse,
                           output logic [1:0] p1_r2);
    int  lf, pw, pm, w1, w2, ti, rnds, e1, e2, rr, gg;
    bit  err, fin;
    pw = 0; pm = 0; w1 = 0; w2 = 0; ti = 0; rnds = 0; gg = 0; err = 0; fin = 0;
    p1_r2 = 2'b00;
    GO = 1'b1; SEED = seed; LEN = len;
    tick();
    GO = 1'b0; SEED = 8'($urandom); LEN = 4'($urandom);
    check("load_start", 8'(START), 1);
    check("load_p1", 8'(P1), 8'(len[3:2]));
    check("load_p2", 8'(P2), 8'(len[1:0]));
    check("load_busy", 8'(BUSY), 1);
    check("load_done", 8'(DONE), 0);
    check("load_err", 8'(ERR), 0);
    check("load_winner", 8'(WINNER), 0);
    check("load_tally", {WINS1 | WINS2 | TIES}, 0);
    lf = (seed == 8'h00) ? 'hA5 : int'(seed);
    tick();
    for (int r = 1; r <= MAXR && !fin; r++) begin
      e1 = move_of(lf % 4, pw == 1, pm);
      e2 = move_of((lf / 4) % 4, pw == 2, pm);
      check("play_p1", 8'(P1), 8'(e1));
      check("play_p2", 8'(P2), 8'(e2));
      check("play_start", 8'(START), 0);
      check("play_busy", 8'(BUSY), 1);
      check("play_wins1", 8'(WINS1), 8'(w1));
      check("play_wins2", 8'(WINS2), 8'(w2));
      check("play_ties", 8'(TIES), 8'(ti));
      check("play_err", 8'(ERR), 8'(err));
      if (r == 2) p1_r2 = P1;
      lf = lfsr_next(lf);
      rr = referee(pol, r, e1, e2);
      case (rr)
        1: begin w1 = (w1 < 31) ? w1 + 1 : 31; pw = 1; pm = e1; end
        2: begin w2 = (w2 < 31) ? w2 + 1 : 31; pw = 2; pm = e2; end
        3: begin ti = (ti < 31) ? ti + 1 : 31; pw = 0; end
        default: err = 1;
      endcase
      rnds++;
      gg = (pol == 5 && r == 2) ? 3 : (w1 >= target) ? 1 : (w2 >= target) ? 2 : 0;
      ROUND = 2'(rr); GAME = 2'(gg);
      if (go_pulse) begin GO = 1'b1; SEED = 8'($urandom); end
      tick();
      check("wait_p1", 8'(P1), 0);
      check("wait_p2", 8'(P2), 0);
      check("wait_busy", 8'(BUSY), 1);
      check("wait_done", 8'(DONE), 0);
      if (r == rst_round) begin
        RST = 1'b1;
        tick();
        RST = 1'b0; GO = 1'b0; ROUND = 2'b00; GAME = 2'b00;
        check_zero("mid_rst");
        return;
      end
      tick();
      GO = 1'b0; ROUND = 2'b00; GAME = 2'b00;
      if (gg != 0 || rnds == MAXR) begin
        fin = 1;
        if (gg == 0) err = 1;
      end
    end
    check("end_reached", 8'(fin), 1);
    check("end_done", 8'(DONE), 1);
    check("end_busy", 8'(BUSY), 0);
    check("end_start", 8'(START), 0);
    check("end_p1", 8'(P1), 0);
    check("end_winner", 8'(WINNER), 8'(gg));
    check("end_wins1", 8'(WINS1), 8'(w1));
    check("end_wins2", 8'(WINS2), 8'(w2));
    check("end_ties", 8'(TIES), 8'(ti));
    check("end_err", 8'(ERR), 8'(err));
    tick();
    tick();
    check("hold_done", 8'(DONE), 1);
    check("hold_winner", 8'(WINNER), 8'(gg));
    check("hold_ties", 8'(TIES), 8'(ti));
    check("hold_err", 8'(ERR), 8'(err));
  endtask

  typedef struct {
    logic [7:0] seed;
    logic [3:0] len;
    logic [1:0] p1;
    logic [1:0] p2;
  } vec_t;

  initial begin
    vec_t       vecs[5];
    logic [1:0] p1_r2;
    vecs[0] = '{8'h00, 4'b0011, 2'b01, 2'b01};
    vecs[1] = '{8'h1B, 4'b1001, 2'b11, 2'b10};
    vecs[2] = '{8'h04, 4'b0110, 2'b01, 2'b01};
    vecs[3] = '{8'hF0, 4'b1111, 2'b01, 2'b01};
    vecs[4] = '{8'h0E, 4'b1100, 2'b10, 2'b11};

    RST = 1'b1; GO = 1'b1; LEN = 4'h0; SEED = 8'h00; ROUND = 2'b00; GAME = 2'b00;
    @(negedge clk);
    tick();
    tick();
    check_zero("reset");
    GO = 1'b0;
    RST = 1'b0;

    // First-move vectors: LOAD strobe then the opening PLAY.
    for (int i = 0; i < 5; i++) begin
      GO = 1'b1; SEED = vecs[i].seed; LEN = vecs[i].len;
      tick();
      GO = 1'b0;
      check("vec_start", 8'(START), 1);
      check("vec_load_p1", 8'(P1), 8'(vecs[i].len[3:2]));
      check("vec_load_p2", 8'(P2), 8'(vecs[i].len[1:0]));
      check("vec_load_busy", 8'(BUSY), 1);
      tick();
      check("vec_play_start", 8'(START), 0);
      check("vec_play_p1", 8'(P1), 8'(vecs[i].p1));
      check("vec_play_p2", 8'(P2), 8'(vecs[i].p2));
      check("vec_play_busy", 8'(BUSY), 1);
      RST = 1'b1;
      tick();
      RST = 1'b0;
    end

    // Reset lands in WAIT of round 3.
    run_match(8'h3C, 4'b0101, 1, 99, 3, 1'b0, p1_r2);

    // P1 wins round 1 with rock; seed 04 offers rock again in round 2.
    run_match(8'h04, 4'b1010, 4, 3, 0, 1'b0, p1_r2);
    check("rotate_p1_r2", 8'(p1_r2), 8'(2'b10));

    // Endless ties run out the round limit.
    run_match(8'h00, 4'b0001, 1, 99, 0, 1'b0, p1_r2);
    check("limit_ties", 8'(TIES), 20);
    check("limit_winner", 8'(WINNER), 0);
    check("limit_err", 8'(ERR), 1);

    // P2 takes three straight rounds while GO is hammered mid-match.
    run_match(8'h5A, 4'b0110, 2, 3, 0, 1'b1, p1_r2);
    check("p2_wins2", 8'(WINS2), 3);
    check("p2_winner", 8'(WINNER), 8'(2'b10));
    check("p2_err", 8'(ERR), 0);

    run_match(8'h77, 4'b1110, 3, 3, 0, 1'b0, p1_r2);
    check("null_err", 8'(ERR), 1);

    run_match(8'h81, 4'b0000, 5, 99, 0, 1'b0, p1_r2);
    check("draw_winner", 8'(WINNER), 8'(2'b11));

    for (int m = 0; m < 8; m++) begin
      run_match(8'($urandom), 4'($urandom), 0, 3, 0, 1'($urandom), p1_r2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
